demux_count_sequencer: RTL and testbench

DEMUX_COUNT_SEQUENCER -- requirements
Module: demux_count_sequencer

---
 rtl/demux_count_sequencer.sv | 153 +++++++++++++++
 tb/tb_demux_count_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_count_sequencer.sv
// LED sequencer: a free-running tick counter paces STATIC, CHASE, BOUNCE and ALL
// patterns onto a registered LED vector, with a one-cycle tick pulse per wrap.
module demux_count_sequencer #(
  parameter int NUM_LEDS    = 4,
  parameter int SEL_WIDTH   = 2,
  parameter int COUNT_LIMIT = 4194303
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Enable,
  input  logic [1:0]           i_Mode,
  input  logic [SEL_WIDTH-1:0] i_Sel,
  output logic [NUM_LEDS-1:0]  o_LED,
  output logic                 o_Tick
);

  localparam int CW = $clog2(COUNT_LIMIT + 1);
  localparam int PW = $clog2(NUM_LEDS);

  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_LIMIT);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] POS_LAST = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0] POS_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] POS_ONE  = PW'(1);

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_ALL    = 2'd3;

  logic [CW-1:0]       cnt_r;
  logic                tog_r;
  logic [PW-1:0]       pos_r;
  logic                dir_r;
  logic [1:0]          prev_mode_r;
  logic                chg_d_r;

  logic                chg_s;
  logic                tick_s;
  logic [CW-1:0]       cnt_nxt_s;
  logic                tog_nxt_s;
  logic [PW-1:0]       pos_nxt_s;
  logic                dir_nxt_s;
  logic                led_upd_s;
  logic [NUM_LEDS-1:0] led_pat_s;
  logic [NUM_LEDS-1:0] led_nxt_s;

  // Next-state: mode change wins over the tick; position/direction move only on ticks
  always_comb begin
    chg_s     = (i_Mode != prev_mode_r);
    tick_s    = i_Enable & ~chg_s & (cnt_r == CNT_LAST);
    cnt_nxt_s = cnt_r;
    tog_nxt_s = tog_r;
    pos_nxt_s = pos_r;
    dir_nxt_s = dir_r;
    if (chg_s) begin
      cnt_nxt_s = CNT_ZERO;
      pos_nxt_s = POS_ZERO;
      dir_nxt_s = 1'b0;
    end else if (i_Enable) begin
      if (tick_s) begin
        cnt_nxt_s = CNT_ZERO;
        tog_nxt_s = ~tog_r;
        case (i_Mode)
          MODE_CHASE: begin
            if (pos_r == POS_LAST) begin
              pos_nxt_s = POS_ZERO;
            end else begin
              pos_nxt_s = pos_r + POS_ONE;
            end
          end
          MODE_BOUNCE: begin
            // Direction flips on arrival at an end so the end value is never repeated
            if (!dir_r) begin
              if (pos_r == POS_LAST) begin
                pos_nxt_s = pos_r - POS_ONE;
                dir_nxt_s = 1'b1;
              end else begin
                pos_nxt_s = pos_r + POS_ONE;
                dir_nxt_s = ((pos_r + POS_ONE) == POS_LAST);
              end
            end else begin
              if (pos_r == POS_ZERO) begin
                pos_nxt_s = POS_ONE;
                dir_nxt_s = 1'b0;
              end else begin
                pos_nxt_s = pos_r - POS_ONE;
                dir_nxt_s = (pos_r != POS_ONE);
              end
            end
          end
          default: begin
            pos_nxt_s = pos_r;
            dir_nxt_s = dir_r;
          end
        endcase
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // LED pattern from current state; refreshed while enabled and for two cycles around a mode change
  always_comb begin
    led_pat_s = {NUM_LEDS{1'b0}};
    led_upd_s = i_Enable | chg_s | chg_d_r;
    case (i_Mode)
      MODE_STATIC: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          led_pat_s[i] = (int'(i_Sel) == i) ? tog_r : 1'b0;
        end
      end
      MODE_CHASE, MODE_BOUNCE: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          led_pat_s[i] = (int'(pos_r) == i);
        end
      end
      MODE_ALL: led_pat_s = {NUM_LEDS{tog_r}};
      default:  led_pat_s = {NUM_LEDS{1'b0}};
    endcase
    if (led_upd_s) begin
      led_nxt_s = led_pat_s;
    end else begin
      led_nxt_s = o_LED;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge i_Clk) begin
    prev_mode_r <= i_Mode;
    if (!i_Rst_L) begin
      cnt_r   <= CNT_ZERO;
      tog_r   <= 1'b0;
      pos_r   <= POS_ZERO;
      dir_r   <= 1'b0;
      chg_d_r <= 1'b0;
      o_Tick  <= 1'b0;
      o_LED   <= {NUM_LEDS{1'b0}};
    end else begin
      cnt_r   <= cnt_nxt_s;
      tog_r   <= tog_nxt_s;
      pos_r   <= pos_nxt_s;
      dir_r   <= dir_nxt_s;
      chg_d_r <= chg_s;
      o_Tick  <= tick_s;
      o_LED   <= led_nxt_s;
    end
  end

endmodule

// File: tb/tb_demux_count_sequencer.sv
// Bench for demux_count_sequencer: a 4-LED and a 3-LED instance share stimulus and are
// compared each cycle against a tick-count based reference model.
module tb_demux_count_sequencer;

  logic       clk = 1'b0;
  logic       rst_l, en;
  logic [1:0] mode, sel;
  logic [3:0] led4;
  logic       tick4;
  logic [2:0] led3;
  logic       tick3;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: index 0 = 4 LEDs, index 1 = 3 LEDs; COUNT_LIMIT = 3 for both
  int         m_cnt[2];
  int         m_ticks[2];
  bit         m_tog[2];
  logic [1:0] m_prev[2];
  bit         m_chgd[2];
  logic [3:0] m_led[2];
  bit         m_tick[2];

  demux_count_sequencer #(.NUM_LEDS(4), .SEL_WIDTH(2), .COUNT_LIMIT(3)) u_dut4 (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Enable(en), .i_Mode(mode), .i_Sel(sel),
    .o_LED(led4), .o_Tick(tick4));

  demux_count_sequencer #(.NUM_LEDS(3), .SEL_WIDTH(2), .COUNT_LIMIT(3)) u_dut3 (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Enable(en), .i_Mode(mode), .i_Sel(sel),
    .o_LED(led3), .o_Tick(tick3));

  always #5 clk = ~clk;

  // Position as a closed form of ticks since the last mode change
  function automatic int mpos(int k, int n);
    int p;
    if (m_prev[k] == 2'd1) return m_ticks[k] % n;
    if (m_prev[k] == 2'd2) begin
      p = m_ticks[k] % (2 * n - 2);
      return (p < n) ? p : (2 * n - 2 - p);
    end
    return 0;
  endfunction

  function automatic logic [3:0] pat(int n, logic [1:0] md, logic [1:0] s, bit tg, int p);
    logic [3:0] r;
    r = 4'b0000;
    case (md)
      2'd0: if (int'(s) < n) r[s] = tg;
      2'd1, 2'd2: r[p] = 1'b1;
      default: for (int i = 0; i < n; i++) r[i] = tg;
    endcase
    return r;
  endfunction

  function automatic void model_step();
    int n;
    bit chg, tk;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 3;
      if (!rst_l) begin
        m_cnt[k] = 0; m_ticks[k] = 0; m_tog[k] = 0; m_prev[k] = mode;
        m_chgd[k] = 0; m_led[k] = 4'b0000; m_tick[k] = 0;
      end else begin
        chg = (mode != m_prev[k]);
        tk  = en && !chg && (m_cnt[k] % 4 == 3);
        if (en || chg || m_chgd[k]) m_led[k] = pat(n, mode, sel, m_tog[k], mpos(k, n));
        m_chgd[k] = chg;
        m_tick[k] = tk;
        if (chg) begin
          m_cnt[k] = 0; m_ticks[k] = 0;
        end else if (en) begin
          m_cnt[k]++;
          if (tk) begin m_ticks[k]++; m_tog[k] = !m_tog[k]; end
        end
        m_prev[k] = mode;
      end
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset(input logic [1:0] md, input logic [1:0] s);
    rst_l = 1'b0; en = 1'b1; mode = md; sel = s;
    cyc(); cyc();
    rst_l = 1'b1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0; en = 1'b1; mode = 2'($urandom); sel = 2'($urandom);
    for (int c = 0; c < 3; c++) begin
      cyc();
      n_checks += 2;
      if ({led4, tick4} !== 5'b00000) begin
        n_fail++; $display("FAIL reset4 c=%0d: led=%b tick=%b, expected 0000/0", c, led4, tick4);
      end
      if ({led3, tick3} !== 4'b0000) begin
        n_fail++; $display("FAIL reset3 c=%0d: led=%b tick=%b, expected 000/0", c, led3, tick3);
      end
    end
    rst_l = 1'b1;
  endtask

  task automatic test_tick_period();
    int first = -1, nt = 0;
    bit prev = 1'b0;
    do_reset(2'd1, 2'd0);
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (tick4 && first < 0) first = c;
      n_checks++;
      if (tick4 && prev) begin
        n_fail++; $display("FAIL tick_double c=%0d: tick=1 on two cycles, expected single pulse", c);
      end
      if (tick4) nt++;
      prev = tick4;
      n_checks += 2;
      if ({led4, tick4} !== {m_led[0], m_tick[0]}) begin
        n_fail++; $display("FAIL period4 c=%0d: led=%b tick=%b, expected %b/%b", c, led4, tick4, m_led[0], m_tick[0]);
      end
      if ({led3, tick3} !== {m_led[1][2:0], m_tick[1]}) begin
        n_fail++; $display("FAIL period3 c=%0d: led=%b tick=%b, expected %b/%b", c, led3, tick3, m_led[1][2:0], m_tick[1]);
      end
    end
    n_checks += 2;
    if (first != 4) begin n_fail++; $display("FAIL first_tick: cycle %0d, expected 4", first); end
    if (nt != 5) begin n_fail++; $display("FAIL tick_count: %0d ticks in 20 cycles, expected 5", nt); end
  endtask

  task automatic test_static();
    do_reset(2'd0, 2'd2);
    for (int c = 1; c <= 16; c++) begin
      cyc();
      if (c == 13) sel = 2'd1;
      n_checks += 2;
      if ({led4, tick4} !== {m_led[0], m_tick[0]}) begin
        n_fail++; $display("FAIL static4 c=%0d: led=%b tick=%b, expected %b/%b", c, led4, tick4, m_led[0], m_tick[0]);
      end
      if ({led3, tick3} !== {m_led[1][2:0], m_tick[1]}) begin
        n_fail++; $display("FAIL static3 c=%0d: led=%b tick=%b, expected %b/%b", c, led3, tick3, m_led[1][2:0], m_tick[1]);
      end
      if (c == 5 || c == 9 || c == 13 || c == 14) begin
        n_checks++;
        if (led4 !== ((c == 9) ? 4'b0000 : (c == 14) ? 4'b0010 : 4'b0100)) begin
          n_fail++; $display("FAIL static_fixed c=%0d: led=%b", c, led4);
        end
      end
    end
  endtask

  task automatic test_chase();
    logic [3:0] e4[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [2:0] e3[6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    int idx = 0;
    bit prev = 1'b1;
    do_reset(2'd1, 2'd0);
    for (int c = 1; c <= 22 && idx < 6; c++) begin
      cyc();
      if (prev) begin
        n_checks += 2;
        if (led4 !== e4[idx]) begin n_fail++; $display("FAIL chase4 step %0d: led=%b, expected %b", idx, led4, e4[idx]); end
        if (led3 !== e3[idx]) begin n_fail++; $display("FAIL chase3 step %0d: led=%b, expected %b", idx, led3, e3[idx]); end
        idx++;
      end
      prev = tick4;
    end
    n_checks++;
    if (idx != 6) begin n_fail++; $display("FAIL chase_steps: %0d, expected 6", idx); end
  endtask

  task automatic test_bounce();
    logic [3:0] e4[7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic [2:0] e3[7] = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b010, 3'b100, 3'b010};
    int idx = 0;
    bit prev = 1'b0;
    do_reset(2'd2, 2'd0);
    for (int c = 1; c <= 32 && idx < 7; c++) begin
      cyc();
      if (prev) begin
        n_checks += 2;
        if (led4 !== e4[idx]) begin n_fail++; $display("FAIL bounce4 tick %0d: led=%b, expected %b", idx + 1, led4, e4[idx]); end
        if (led3 !== e3[idx]) begin n_fail++; $display("FAIL bounce3 tick %0d: led=%b, expected %b", idx + 1, led3, e3[idx]); end
        idx++;
      end
      prev = tick4;
    end
    n_checks++;
    if (idx != 7) begin n_fail++; $display("FAIL bounce_steps: %0d, expected 7", idx); end
  endtask

  task automatic test_pause();
    logic [3:0] hold;
    int wait_c = -1;
    do_reset(2'd1, 2'd0);
    for (int c = 1; c <= 6; c++) cyc();
    hold = m_led[0];
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      n_checks += 2;
      if ({led4, tick4} !== {hold, 1'b0}) begin
        n_fail++; $display("FAIL pause4 c=%0d: led=%b tick=%b, expected %b/0", c, led4, tick4, hold);
      end
      if ({led3, tick3} !== {m_led[1][2:0], 1'b0}) begin
        n_fail++; $display("FAIL pause3 c=%0d: led=%b tick=%b, expected %b/0", c, led3, tick3, m_led[1][2:0]);
      end
    end
    en = 1'b1;
    for (int c = 1; c <= 8 && wait_c < 0; c++) begin
      cyc();
      if (tick4) wait_c = c;
    end
    n_checks++;
    if (wait_c != 2) begin n_fail++; $display("FAIL resume_tick: after %0d cycles, expected 2", wait_c); end
  endtask

  task automatic test_three_leds();
    do_reset(2'd0, 2'd3);
    for (int c = 1; c <= 12; c++) begin
      cyc();
      n_checks += 2;
      if (led3 !== 3'b000) begin n_fail++; $display("FAIL sel_oob3 c=%0d: led=%b, expected 000", c, led3); end
      if ({led4, tick4} !== {m_led[0], m_tick[0]}) begin
        n_fail++; $display("FAIL sel3_dut4 c=%0d: led=%b tick=%b, expected %b/%b", c, led4, tick4, m_led[0], m_tick[0]);
      end
    end
    mode = 2'd2;
    for (int c = 0; c < 11; c++) cyc();
    rst_l = 1'b0;
    cyc();
    n_checks++;
    if ({led3, tick3} !== 4'b0000) begin n_fail++; $display("FAIL midreset3: led=%b tick=%b, expected 000/0", led3, tick3); end
    rst_l = 1'b1;
    cyc();
    n_checks++;
    if ({led3, tick3} !== 4'b0010) begin n_fail++; $display("FAIL postreset3: led=%b tick=%b, expected 001/0", led3, tick3); end
  endtask

  task automatic test_random();
    do_reset(2'd1, 2'd0);
    for (int c = 0; c < 500; c++) begin
      en    = (($urandom % 8) != 0);
      rst_l = (($urandom % 70) != 0);
      sel   = 2'($urandom);
      if (($urandom % 25) == 0) mode = 2'($urandom);
      cyc();
      n_checks += 2;
      if ({led4, tick4} !== {m_led[0], m_tick[0]}) begin
        n_fail++; $display("FAIL random4 c=%0d: led=%b tick=%b, expected %b/%b", c, led4, tick4, m_led[0], m_tick[0]);
      end
      if ({led3, tick3} !== {m_led[1][2:0], m_tick[1]}) begin
        n_fail++; $display("FAIL random3 c=%0d: led=%b tick=%b, expected %b/%b", c, led3, tick3, m_led[1][2:0], m_tick[1]);
      end
    end
  endtask

  initial begin
    rst_l = 1'b0; en = 1'b0; mode = 2'd0; sel = 2'd0;
    test_reset();
    test_tick_period();
    test_static();
    test_chase();
    test_bounce();
    test_pause();
    test_three_leds();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
